// File: rtl/iq_stream_framer.sv
`default_nettype none
// ============================================================================
// Module   : iq_stream_framer
// Purpose  : Decimates I/Q pairs, sign-extends them to 16 bits and packs {Q,I}
//            words with a frame-start strobe. IQ_FRAMER_TESTPAT_EN adds a
//            counting test source selected by test_mode.
// Revision : 1.0
// ============================================================================
module iq_stream_framer #(
   parameter int IN_W      = 12,
   parameter int FRAME_LEN = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            stop,
   input  logic [3:0]      dec,
   input  logic [IN_W-1:0] in_i,
   input  logic [IN_W-1:0] in_q,
   input  logic            in_valid,
`ifdef IQ_FRAMER_TESTPAT_EN
   input  logic            test_mode,
`endif
   output logic [31:0]     dout,
   output logic            den,
   output logic            dsync,
   output logic            busy,
   output logic [15:0]     frame_cnt
);

   localparam int                c_WC_W      = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam logic [c_WC_W-1:0] c_LAST_WORD = c_WC_W'(FRAME_LEN - 1);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_RUN      = 2'd1;
   localparam logic [1:0] c_STOPPING = 2'd2;

   logic [1:0]        r_state;
   logic [3:0]        r_dec;
   logic [3:0]        r_dec_cnt;
   logic [c_WC_W-1:0] r_word_cnt;
   logic [15:0]       r_frame_cnt;
   logic [31:0]       r_dout;
   logic              r_den;
   logic              r_dsync;

   logic [15:0]       w_i16;
   logic [15:0]       w_q16;
   logic [31:0]       w_word;
   logic              w_active;
   logic              w_emit;
   logic              w_last;

   generate
      if (IN_W >= 16) begin : g_ext_full
         assign w_i16 = in_i[15:0];
         assign w_q16 = in_q[15:0];
      end else begin : g_ext_sign
         assign w_i16 = {{(16-IN_W){in_i[IN_W-1]}}, in_i};
         assign w_q16 = {{(16-IN_W){in_q[IN_W-1]}}, in_q};
      end
   endgenerate

   assign w_active = (r_state != c_IDLE);
   assign w_emit   = w_active && in_valid && (r_dec_cnt == 4'd0);
   assign w_last   = w_emit && (r_word_cnt == c_LAST_WORD);

`ifdef IQ_FRAMER_TESTPAT_EN
   logic [15:0] r_tp_i;
   logic [15:0] r_tp_q;

   // Counters advance on every emitted word so the pattern stays word-aligned
   // even while test_mode toggles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tp_i <= 16'd0;
         r_tp_q <= 16'd0;
      end else if (!w_active && start) begin
         r_tp_i <= 16'd0;
         r_tp_q <= 16'd0;
      end else if (w_emit) begin
         r_tp_i <= r_tp_i - 16'd1;
         r_tp_q <= r_tp_q + 16'd1;
      end
   end

   assign w_word = test_mode ? {r_tp_q, r_tp_i} : {w_q16, w_i16};
`else
   assign w_word = {w_q16, w_i16};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_dec       <= 4'd0;
         r_dec_cnt   <= 4'd0;
         r_word_cnt  <= '0;
         r_frame_cnt <= 16'd0;
         r_dout      <= 32'd0;
         r_den       <= 1'b0;
         r_dsync     <= 1'b0;
      end else begin
         r_den   <= 1'b0;
         r_dsync <= 1'b0;

         case (r_state)
            c_IDLE: begin
               if (start) begin
                  r_state     <= c_RUN;
                  r_dec       <= dec;
                  r_dec_cnt   <= 4'd0;
                  r_word_cnt  <= '0;
                  r_frame_cnt <= 16'd0;
               end
            end
            c_RUN: begin
               // A stop landing on a frame's last word has nothing left to finish.
               if (stop) r_state <= w_last ? c_IDLE : c_STOPPING;
            end
            c_STOPPING: begin
               if (w_last) r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase

         if (w_active && in_valid) begin
            r_dec_cnt <= (r_dec_cnt == 4'd0) ? r_dec : r_dec_cnt - 4'd1;
         end

         if (w_emit) begin
            r_dout  <= w_word;
            r_den   <= 1'b1;
            r_dsync <= (r_word_cnt == '0);
            if (w_last) begin
               r_word_cnt  <= '0;
               r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
               r_word_cnt  <= r_word_cnt + c_WC_W'(1);
            end
         end
      end
   end

   // The final word's strobe still counts as busy time.
   assign busy      = w_active | r_den;
   assign dout      = r_dout;
   assign den       = r_den;
   assign dsync     = r_dsync;
   assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_iq_stream_framer.sv
`default_nettype none
// Testbench for iq_stream_framer: randomized stimulus checked against a
// word/frame-counting reference model (IN_W=12, FRAME_LEN=4).
module tb_iq_stream_framer;

   localparam int FL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, in_valid, test_mode;
   logic [3:0]  dec;
   logic [11:0] in_i, in_q;
   logic [31:0] dout;
   logic        den, dsync, busy;
   logic [15:0] frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic        m_active, m_stopping, m_den, m_dsync, m_busy;
   logic [3:0]  m_dec;
   int          m_nvalid, m_words;
   logic [15:0] m_frame, m_tpi, m_tpq;
   logic [31:0] m_dout;

   iq_stream_framer #(.IN_W(12), .FRAME_LEN(FL)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dec(dec),
      .in_i(in_i), .in_q(in_q), .in_valid(in_valid),
`ifdef IQ_FRAMER_TESTPAT_EN
      .test_mode(test_mode),
`endif
      .dout(dout), .den(den), .dsync(dsync), .busy(busy), .frame_cnt(frame_cnt)
   );

   always #5 clk = ~clk;

   task automatic model_reset;
      m_active = 0; m_stopping = 0; m_den = 0; m_dsync = 0; m_busy = 0;
      m_dec = 0; m_nvalid = 0; m_words = 0; m_frame = 0; m_dout = 0;
      m_tpi = 0; m_tpq = 0;
   endtask

   // Drive one cycle of inputs, advance the model, then sample 1 ns after the edge.
   task automatic step(input logic s, input logic p, input logic v,
                       input logic [11:0] i, input logic [11:0] q);
      logic emit, last;
      start = s; stop = p; in_valid = v; in_i = i; in_q = q;
      emit = 0; last = 0; m_den = 0; m_dsync = 0;
      if (!m_active) begin
         if (s) begin
            m_active = 1; m_stopping = 0; m_dec = dec; m_nvalid = 0;
            m_words = 0; m_frame = 0; m_tpi = 0; m_tpq = 0;
         end
      end else begin
         emit = v && ((m_nvalid % (int'(m_dec) + 1)) == 0);
         last = emit && ((m_words % FL) == FL - 1);
         if (v) m_nvalid++;
         if (emit) begin
            m_den   = 1;
            m_dsync = ((m_words % FL) == 0);
            m_dout  = {{4{q[11]}}, q, {4{i[11]}}, i};
`ifdef IQ_FRAMER_TESTPAT_EN
            if (test_mode) m_dout = {m_tpq, m_tpi};
            m_tpi = m_tpi - 16'd1;
            m_tpq = m_tpq + 16'd1;
`endif
            m_words++;
            if (last) m_frame = m_frame + 16'd1;
         end
         if (p) m_stopping = 1;
         if (last && m_stopping) m_active = 0;
      end
      m_busy = m_active || m_den;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      #2 rst_n = 0;
      model_reset();
      start = 0; stop = 0; in_valid = 0; in_i = 0; in_q = 0;
      @(posedge clk);
      #1 rst_n = 1;
   endtask

   task automatic test_reset;
      n_checks++;
      if ({den, dsync, busy, frame_cnt, dout} !== 51'd0) begin
         n_fail++;
         $display("FAIL reset: got den=%0b dsync=%0b busy=%0b frame=%0d dout=%h, expected all zero",
                  den, dsync, busy, frame_cnt, dout);
      end
   endtask

   task automatic test_full_scale;
      apply_reset();
      dec = 0;
      step(1, 0, 0, 12'h0, 12'h0);
      for (int k = 0; k < 6; k++) begin
         step(0, 0, 1, 12'h800, 12'h7FF);
         n_checks++;
         if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout} ||
             den !== 1'b1 || dout !== 32'h07FF_F800) begin
            n_fail++;
            $display("FAIL full_scale[%0d]: got den=%0b dsync=%0b busy=%0b frame=%0d dout=%h, expected den=1 dsync=%0b frame=%0d dout=07fff800",
                     k, den, dsync, busy, frame_cnt, dout, m_dsync, m_frame);
         end
      end
   endtask

   task automatic test_framing;
      int sync_mask;
      sync_mask = 0;
      apply_reset();
      dec = 0;
      step(1, 0, 0, 12'h0, 12'h0);
      for (int k = 0; k < 12; k++) begin
         step(0, 0, 1, 12'($urandom), 12'($urandom));
         if (dsync === 1'b1) sync_mask |= (1 << k);
         n_checks++;
         if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout}) begin
            n_fail++;
            $display("FAIL framing[%0d]: got den=%0b dsync=%0b busy=%0b frame=%0d dout=%h, expected den=%0b dsync=%0b busy=%0b frame=%0d dout=%h",
                     k, den, dsync, busy, frame_cnt, dout, m_den, m_dsync, m_busy, m_frame, m_dout);
         end
      end
      n_checks++;
      if (sync_mask !== 32'h111 || frame_cnt !== 16'd3) begin
         n_fail++;
         $display("FAIL framing_summary: got sync_mask=%h frame=%0d, expected sync_mask=111 frame=3",
                  sync_mask, frame_cnt);
      end
   endtask

   task automatic test_decimation;
      logic [15:0] got[$];
      apply_reset();
      dec = 4'd2;
      step(1, 0, 0, 12'h0, 12'h0);
      for (int k = 0; k < 10; k++) begin
         step(0, 0, k < 9, 12'(k), 12'($urandom));
         if (den === 1'b1) got.push_back(dout[15:0]);
         n_checks++;
         if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout}) begin
            n_fail++;
            $display("FAIL decimation[%0d]: got den=%0b dsync=%0b frame=%0d dout=%h, expected den=%0b dsync=%0b frame=%0d dout=%h",
                     k, den, dsync, frame_cnt, dout, m_den, m_dsync, m_frame, m_dout);
         end
      end
      n_checks++;
      if (got.size() != 3 || got[0] !== 16'd0 || got[1] !== 16'd3 || got[2] !== 16'd6) begin
         n_fail++;
         $display("FAIL decimation_words: got %0d words, expected 3 words with I=0,3,6", got.size());
      end
   endtask

   task automatic test_stop;
      int dens;
      // stop after word 1: words 2 and 3 still follow
      apply_reset();
      dec = 0;
      step(0, 1, 1, 12'h0, 12'h0);
      step(1, 0, 0, 12'h0, 12'h0);
      dens = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, k == 2, 1, 12'($urandom), 12'($urandom));
         if (den === 1'b1) dens++;
         n_checks++;
         if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout}) begin
            n_fail++;
            $display("FAIL stop_mid[%0d]: got den=%0b dsync=%0b busy=%0b frame=%0d, expected den=%0b dsync=%0b busy=%0b frame=%0d",
                     k, den, dsync, busy, frame_cnt, m_den, m_dsync, m_busy, m_frame);
         end
      end
      n_checks++;
      if (dens != 4 || busy !== 1'b0 || frame_cnt !== 16'd1) begin
         n_fail++;
         $display("FAIL stop_mid_summary: got words=%0d busy=%0b frame=%0d, expected words=4 busy=0 frame=1",
                  dens, busy, frame_cnt);
      end
      // stop coincident with word 3: idle right after, no more strobes
      step(1, 0, 0, 12'h0, 12'h0);
      dens = 0;
      for (int k = 0; k < 8; k++) begin
         step(0, k == 3, 1, 12'($urandom), 12'($urandom));
         if (den === 1'b1) dens++;
         n_checks++;
         if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout}) begin
            n_fail++;
            $display("FAIL stop_last[%0d]: got den=%0b dsync=%0b busy=%0b frame=%0d, expected den=%0b dsync=%0b busy=%0b frame=%0d",
                     k, den, dsync, busy, frame_cnt, m_den, m_dsync, m_busy, m_frame);
         end
      end
      n_checks++;
      if (dens != 4) begin
         n_fail++;
         $display("FAIL stop_last_count: got words=%0d, expected 4", dens);
      end
   endtask

   task automatic test_reset_midframe;
      apply_reset();
      dec = 0;
      step(1, 0, 0, 12'h0, 12'h0);
      step(0, 0, 1, 12'h123, 12'h456);
      step(0, 0, 1, 12'h321, 12'h654);
      #2 rst_n = 0;
      model_reset();
      #1;
      n_checks++;
      if ({den, dsync, busy, frame_cnt, dout} !== 51'd0) begin
         n_fail++;
         $display("FAIL reset_midframe: got den=%0b dsync=%0b busy=%0b frame=%0d dout=%h, expected all zero",
                  den, dsync, busy, frame_cnt, dout);
      end
      @(posedge clk);
      #1 rst_n = 1;
      step(1, 0, 0, 12'h0, 12'h0);
      step(0, 0, 1, 12'h00A, 12'hFF5);
      n_checks++;
      if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout} ||
          dsync !== 1'b1 || dout !== 32'hFFF5_000A) begin
         n_fail++;
         $display("FAIL restart: got den=%0b dsync=%0b frame=%0d dout=%h, expected den=1 dsync=1 frame=0 dout=fff5000a",
                  den, dsync, frame_cnt, dout);
      end
   endtask

   task automatic test_random;
      for (int t = 0; t < 6; t++) begin
         int cyc, stop_at;
         dec = 4'($urandom_range(0, 3));
         stop_at = $urandom_range(0, 30);
         step(1, 0, $urandom_range(0, 1) == 1, 12'($urandom), 12'($urandom));
         cyc = 0;
         while ((m_active || m_den) && cyc < 400) begin
            dec = 4'($urandom);
            step($urandom_range(0, 9) == 0, cyc == stop_at || $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0, 12'($urandom), 12'($urandom));
            cyc++;
            n_checks++;
            if ({den, dsync, busy, frame_cnt, dout} !== {m_den, m_dsync, m_busy, m_frame, m_dout}) begin
               n_fail++;
               $display("FAIL random[%0d.%0d]: got den=%0b dsync=%0b busy=%0b frame=%0d dout=%h, expected den=%0b dsync=%0b busy=%0b frame=%0d dout=%h",
                        t, cyc, den, dsync, busy, frame_cnt, dout, m_den, m_dsync, m_busy, m_frame, m_dout);
            end
         end
         n_checks++;
         if (cyc >= 400) begin
            n_fail++;
            $display("FAIL random_timeout[%0d]: got still busy after %0d cycles, expected idle", t, cyc);
         end
      end
   endtask

`ifdef IQ_FRAMER_TESTPAT_EN
   task automatic test_testpat;
      logic [31:0] want[3];
      want[0] = 32'h0000_0000; want[1] = 32'h0001_FFFF; want[2] = 32'h0002_FFFE;
      apply_reset();
      dec = 0;
      test_mode = 1;
      step(1, 0, 0, 12'h0, 12'h0);
      for (int k = 0; k < 3; k++) begin
         step(0, 0, 1, 12'($urandom), 12'($urandom));
         n_checks++;
         if (den !== 1'b1 || dout !== want[k] || dout !== m_dout) begin
            n_fail++;
            $display("FAIL testpat[%0d]: got den=%0b dout=%h, expected den=1 dout=%h", k, den, dout, want[k]);
         end
      end
      test_mode = 0;
   endtask
`endif

   initial begin
      rst_n = 0; start = 0; stop = 0; in_valid = 0; in_i = 0; in_q = 0;
      dec = 0; test_mode = 0;
      model_reset();
      @(posedge clk);
      #1;
      test_reset();
      @(posedge clk);
      #1 rst_n = 1;
      step(0, 1, 1, 12'h5, 12'h5);
      test_reset();
      test_full_scale();
      test_framing();
      test_decimation();
      test_stop();
      test_reset_midframe();
      test_random();
`ifdef IQ_FRAMER_TESTPAT_EN
      test_testpat();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
